// File: rtl/prach_pkt_framer.sv
// PRACH packet framer: ping-pong sample banks feeding an Avalon-ST source.
// A header of HDR_BEATS beats is followed by cfg_rd_len payload beats per packet.
// Ports:
//   clk, rst (sync, active-high)
//   din_dr/din_di/din_dv: IQ sample input
//   sync_in: symbol start; latches hdr_in, cfg_rd_len, cfg_start_thr
//   avst_source_*: packet output, readyLatency 0
//   stat_overrun / stat_overrun_cnt: dropped-packet pulse and saturating count
module prach_pkt_framer #(
   parameter int IQ_W       = 16,
   parameter int DATA_W     = 64,
   parameter int BANK_DEPTH = 2048,
   parameter int HDR_W      = 120,
   parameter int HDR_BEATS  = 2,
   parameter int RD_OFFSET  = 0,
   parameter int LEN_W      = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [IQ_W-1:0]   din_dr,
   input  logic [IQ_W-1:0]   din_di,
   input  logic              din_dv,
   input  logic              sync_in,
   input  logic [HDR_W-1:0]  hdr_in,
   input  logic [LEN_W-1:0]  cfg_rd_len,
   input  logic [LEN_W-1:0]  cfg_start_thr,
   output logic [DATA_W-1:0] avst_source_data,
   output logic              avst_source_valid,
   output logic              avst_source_startofpacket,
   output logic              avst_source_endofpacket,
   input  logic              avst_source_ready,
   output logic              stat_overrun,
   output logic [15:0]       stat_overrun_cnt
);

   localparam int IQ_PER_BEAT = DATA_W / (2 * IQ_W);
   localparam int BANK_BEATS  = BANK_DEPTH / IQ_PER_BEAT;
   localparam int BA_W        = $clog2(BANK_BEATS);
   localparam int CNT_W       = $clog2(BANK_DEPTH + 1);
   localparam int PAD_W       = HDR_BEATS * DATA_W;
   localparam int SW          = 2 * IQ_W;

   typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

   logic [DATA_W-1:0] mem [0:2*BANK_BEATS-1];

   logic [HDR_W-1:0] ctx_hdr [2];
   logic [LEN_W-1:0] ctx_len [2];
   logic [LEN_W-1:0] ctx_thr [2];

   logic             wr_bank;
   logic             armed;
   logic [CNT_W-1:0] wr_cnt;
   logic             start_q;
   logic             start_bank;

   state_t            state;
   logic              rd_bank;
   logic [LEN_W-1:0]  pkt_cnt;
   logic [LEN_W-1:0]  pkt_len;
   logic [HDR_W-1:0]  pkt_hdr;
   logic [DATA_W-1:0] data;
   logic              valid;
   logic              sop;
   logic              eop;
   logic              overrun;
   logic [15:0]       ovr_cnt;

   // A coincident sync_in redirects this cycle's sample to slot 0 of the new bank.
   logic             cur_bank;
   logic [CNT_W-1:0] cur_cnt;
   logic [LEN_W-1:0] cur_thr;
   logic             accept;
   logic             start_ev;
   logic [BA_W-1:0]  waddr;
   logic [CNT_W-1:0] lane;
   logic [BA_W-1:0]  raddr;

   always_comb begin
      cur_bank = sync_in ? ~wr_bank : wr_bank;
      cur_cnt  = sync_in ? '0 : wr_cnt;
      cur_thr  = sync_in ? cfg_start_thr : ctx_thr[wr_bank];
      accept   = (armed | sync_in) & din_dv
               & (cur_cnt < CNT_W'(BANK_DEPTH));
      start_ev = accept && (cur_thr != '0)
               && (32'(cur_cnt) + 32'd1 == 32'(cur_thr));
      waddr    = BA_W'(cur_cnt / CNT_W'(IQ_PER_BEAT));
      lane     = cur_cnt % CNT_W'(IQ_PER_BEAT);
      // Address of the payload beat to present after the current transfer.
      raddr    = BA_W'(RD_OFFSET)
               + ((state == PAY) ? BA_W'(pkt_cnt + LEN_W'(1)) : '0);
   end

   function automatic logic [DATA_W-1:0] hdr_slice(
      input logic [HDR_W-1:0] h,
      input int               idx
   );
      logic [PAD_W-1:0] p;
      p = PAD_W'(h) << (PAD_W - HDR_W);
      return p[(HDR_BEATS-1-idx)*DATA_W +: DATA_W];
   endfunction

   always_ff @(posedge clk) begin
      if (accept)
         mem[{cur_bank, waddr}][lane*SW +: SW] <= {din_di, din_dr};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         armed      <= 1'b0;
         wr_bank    <= 1'b0;
         wr_cnt     <= '0;
         start_q    <= 1'b0;
         start_bank <= 1'b0;
         ctx_hdr[0] <= '0;
         ctx_hdr[1] <= '0;
         ctx_len[0] <= '0;
         ctx_len[1] <= '0;
         ctx_thr[0] <= '0;
         ctx_thr[1] <= '0;
      end else begin
         start_q    <= start_ev;
         start_bank <= cur_bank;
         wr_cnt     <= accept ? cur_cnt + CNT_W'(1) : cur_cnt;
         if (sync_in) begin
            armed             <= 1'b1;
            wr_bank           <= cur_bank;
            ctx_hdr[cur_bank] <= hdr_in;
            ctx_len[cur_bank] <= cfg_rd_len;
            ctx_thr[cur_bank] <= cfg_start_thr;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         valid   <= 1'b0;
         sop     <= 1'b0;
         eop     <= 1'b0;
         data    <= '0;
         rd_bank <= 1'b0;
         pkt_cnt <= '0;
         pkt_len <= '0;
         pkt_hdr <= '0;
         overrun <= 1'b0;
         ovr_cnt <= '0;
      end else begin
         overrun <= 1'b0;
         if (start_q && state != IDLE) begin
            overrun <= 1'b1;
            if (ovr_cnt != '1)
               ovr_cnt <= ovr_cnt + 16'd1;
         end
         unique case (state)
            IDLE: if (start_q) begin
               state   <= HDR;
               rd_bank <= start_bank;
               pkt_hdr <= ctx_hdr[start_bank];
               pkt_len <= ctx_len[start_bank];
               pkt_cnt <= '0;
               valid   <= 1'b1;
               sop     <= 1'b1;
               eop     <= (HDR_BEATS == 1) && (ctx_len[start_bank] == '0);
               data    <= hdr_slice(ctx_hdr[start_bank], 0);
            end
            HDR: if (avst_source_ready) begin
               sop <= 1'b0;
               if (pkt_cnt == LEN_W'(HDR_BEATS - 1)) begin
                  pkt_cnt <= '0;
                  if (pkt_len == '0) begin
                     state <= IDLE;
                     valid <= 1'b0;
                     eop   <= 1'b0;
                  end else begin
                     state <= PAY;
                     data  <= mem[{rd_bank, raddr}];
                     eop   <= (pkt_len == LEN_W'(1));
                  end
               end else begin
                  pkt_cnt <= pkt_cnt + LEN_W'(1);
                  data    <= hdr_slice(pkt_hdr, int'(pkt_cnt) + 1);
                  eop     <= (int'(pkt_cnt) + 2 == HDR_BEATS)
                          && (pkt_len == '0);
               end
            end
            PAY: if (avst_source_ready) begin
               if (pkt_cnt + LEN_W'(1) == pkt_len) begin
                  state <= IDLE;
                  valid <= 1'b0;
                  eop   <= 1'b0;
               end else begin
                  pkt_cnt <= pkt_cnt + LEN_W'(1);
                  data    <= mem[{rd_bank, raddr}];
                  eop     <= (pkt_cnt + LEN_W'(2) == pkt_len);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign avst_source_data          = data;
   assign avst_source_valid         = valid;
   assign avst_source_startofpacket = sop;
   assign avst_source_endofpacket   = eop;
   assign stat_overrun              = overrun;
   assign stat_overrun_cnt          = ovr_cnt;

endmodule

// File: doc/prach_pkt_framer.md
PRACH_PKT_FRAMER -- requirements
Module: prach_pkt_framer

Interface
REQ-001 Parameters SHALL be: IQ_W (16), per-component sample width; DATA_W (64), output beat width; BANK_DEPTH (2048), samples per bank; HDR_W (120), header width; HDR_BEATS (2), header beats per packet; RD_OFFSET (0), first payload beat within bank; LEN_W (12), cfg field width.
REQ-002 Derived constant IQ_PER_BEAT SHALL equal DATA_W/(2*IQ_W) and SHALL be an integer power of two.
REQ-003 Ports SHALL be:
- clk  in  1  sole clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- din_dr  in  IQ_W  real part
- din_di  in  IQ_W  imaginary part
- din_dv  in  1  sample valid
- sync_in  in  1  symbol start strobe
- hdr_in  in  HDR_W  header, sampled on sync_in
- cfg_rd_len  in  LEN_W  payload beats, sampled on sync_in
- cfg_start_thr  in  LEN_W  samples before read start, sampled on sync_in
- avst_source_data  out  DATA_W  beat data
- avst_source_valid  out  1  beat valid
- avst_source_startofpacket  out  1  first beat
- avst_source_endofpacket  out  1  last beat
- avst_source_ready  in  1  sink ready, readyLatency 0
- stat_overrun  out  1  one-cycle pulse, packet dropped
- stat_overrun_cnt  out  16  saturating drop count

Function
REQ-004 Storage SHALL be two banks (ping-pong) of BANK_DEPTH samples; the RAM SHALL NOT be reset.
REQ-005 sync_in SHALL toggle wr_bank, clear wr_cnt, and latch hdr_in, cfg_rd_len and cfg_start_thr into the context of the new bank.
REQ-006 Sample k (k = wr_cnt) SHALL be stored as {din_di,din_dr} in beat k/IQ_PER_BEAT, lane k%IQ_PER_BEAT; lane 0 SHALL be the LSBs.
REQ-007 sync_in and din_dv in the same cycle SHALL write that sample as sample 0 of the new bank.
REQ-008 Writes with wr_cnt >= BANK_DEPTH SHALL be dropped; wr_cnt SHALL saturate.
REQ-009 din_dv before the first sync_in after reset SHALL be ignored.
REQ-010 The start event SHALL occur when the write of sample index cfg_start_thr-1 is accepted; cfg_start_thr = 0 SHALL produce no start.
REQ-011 FSM states SHALL be IDLE, HDR and PAY; a start event in IDLE SHALL move to HDR and bind rd_bank to the current wr_bank context.
REQ-012 HDR SHALL emit HDR_BEATS beats carrying the latched header MSB-first in DATA_W slices; the final slice SHALL be zero-padded in its LSBs.
REQ-013 PAY SHALL emit cfg_rd_len beats read from bank beats RD_OFFSET .. RD_OFFSET+cfg_rd_len-1, in order.
REQ-014 If cfg_rd_len = 0, the last header beat SHALL carry eop and the FSM SHALL return to IDLE.
REQ-015 sop SHALL be asserted only on header beat 0, and eop only on the final packet beat.
REQ-016 A beat SHALL transfer when valid && ready; while valid && !ready, data, sop and eop SHALL be held stable.
REQ-017 With the start event's sample at cycle t, valid with sop SHALL first be high in cycle t+2.
REQ-018 With ready held high, the packet SHALL be gapless: HDR_BEATS+cfg_rd_len consecutive cycles.
REQ-019 A start event while the FSM is not IDLE SHALL drop that packet, pulse stat_overrun for one cycle, and increment stat_overrun_cnt, saturating at 0xFFFF; the packet in progress SHALL be unaffected.
REQ-020 Payload integrity SHALL be guaranteed only if cfg_start_thr >= (RD_OFFSET+cfg_rd_len)*IQ_PER_BEAT; otherwise framing SHALL remain correct and payload content is unspecified.

Reset
REQ-021 While rst is high: all outputs 0, FSM IDLE, wr_bank 0, wr_cnt 0, writer disarmed, overrun count 0.
REQ-022 rst mid-packet SHALL deassert valid in the next cycle with no eop emitted; the first start after reset SHALL produce a complete packet.

Verification
REQ-023 Defaults, cfg_rd_len=864, cfg_start_thr=1728, ramp samples (dr=k, di=~k), ready=1 -> 866 gapless beats; sop on beat 0; header beats = hdr[119:56], {hdr[55:0],8'h0}; beat 2 = {~1,1,~0,0}; eop on beat 865.
REQ-024 Same stimulus with ready toggled by a random 50% pattern -> identical beat sequence, with no beat changing while stalled.
REQ-025 Second sync_in and start event issued while packet 1 is at beat 100 with ready=0 -> stat_overrun single pulse, count=1; packet 1 completes intact; no packet 2.
REQ-026 cfg_rd_len=0 -> 2-beat packet, with sop on beat 0 and eop on beat 1.
REQ-027 rst asserted at beat 300 -> valid=0 next cycle; next symbol yields a full correct packet, with count=0.
REQ-028 sync_in coincident with din_dv, plus 2100 samples in one symbol -> the coincident sample lands at beat 0 lane 0; samples beyond 2047 are dropped; no corruption of the other bank.
